// File: rtl/debug_unit_controller.sv
// -----------------------------------------------------------------------------
// debug_unit_controller
//
// Host-driven debug sequencer for the pipelined MIPS core. A byte-stream link
// (UART RX/TX byte interfaces) carries single-byte commands from the host:
//   'L' : load a program into instruction memory (4 bytes per word, MSB first,
//         terminated by the HALT word 0xFFFFFFFF or by the last memory slot)
//   'C' : run the pipeline continuously until HALT commits
//   'S' : advance the pipeline by exactly one clock
// After every run or step, PC and R0..R31 are streamed back to the host
// (132 bytes, each word MSB first).
//
// Ports
//   i_clk, i_reset          : clock, asynchronous active-low reset
//   i_rx_data, i_rx_valid   : received byte and its one-cycle strobe
//   o_tx_data, o_tx_start   : byte to send and its one-cycle start strobe
//   i_tx_done               : transmitter finished the current byte
//   o_imem_we/addr/data     : instruction-memory write port
//   o_pipeline_enable       : advances pipeline registers and PC
//   o_pipeline_flush        : one-cycle pulse clearing the pipeline, PC := 0
//   i_halt                  : HALT decoded and committed
//   i_pc                    : current PC
//   o_reg_addr, i_reg_data  : register-file debug read port (combinational)
//   o_halted                : program has reached HALT
//   o_state                 : current FSM state, for debug LEDs
// -----------------------------------------------------------------------------
module debug_unit_controller #(
    parameter int NB_DATA     = 32,
    parameter int IMEM_ADDR_W = 10,
    parameter int NB_REG_ADDR = 5
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_valid,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done,
    output logic                   o_imem_we,
    output logic [IMEM_ADDR_W-1:0] o_imem_addr,
    output logic [NB_DATA-1:0]     o_imem_data,
    output logic                   o_pipeline_enable,
    output logic                   o_pipeline_flush,
    input  logic                   i_halt,
    input  logic [NB_DATA-1:0]     i_pc,
    output logic [NB_REG_ADDR-1:0] o_reg_addr,
    input  logic [NB_DATA-1:0]     i_reg_data,
    output logic                   o_halted,
    output logic [2:0]             o_state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_LOAD_WR   = 3'd2,
        ST_RUN       = 3'd3,
        ST_STEP      = 3'd4,
        ST_DUMP_LD   = 3'd5,
        ST_DUMP_TX   = 3'd6,
        ST_DUMP_WAIT = 3'd7
    } state_e;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;

    // Dump index 0 is the PC, 1..2^NB_REG_ADDR are the registers.
    localparam int                IDX_W    = NB_REG_ADDR + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = {1'b1, {NB_REG_ADDR{1'b0}}};

    state_e                 state_q, state_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic                   imem_we_q, imem_we_d;
    logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [NB_DATA-1:0]     imem_data_q, imem_data_d;
    logic                   pipe_en_q, pipe_en_d;
    logic                   flush_q, flush_d;
    logic [NB_REG_ADDR-1:0] reg_addr_q, reg_addr_d;
    logic                   halted_q, halted_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [IMEM_ADDR_W-1:0] word_addr_q, word_addr_d;
    logic [NB_DATA-1:0]     asm_q, asm_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NB_DATA-1:0]     dump_word_q, dump_word_d;

    logic [NB_DATA-1:0]     asm_next;
    logic [NB_DATA-1:0]     dump_sel;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            pipe_en_q   <= 1'b0;
            flush_q     <= 1'b0;
            reg_addr_q  <= '0;
            halted_q    <= 1'b0;
            byte_cnt_q  <= '0;
            word_addr_q <= '0;
            asm_q       <= '0;
            idx_q       <= '0;
            dump_word_q <= '0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            pipe_en_q   <= pipe_en_d;
            flush_q     <= flush_d;
            reg_addr_q  <= reg_addr_d;
            halted_q    <= halted_d;
            byte_cnt_q  <= byte_cnt_d;
            word_addr_q <= word_addr_d;
            asm_q       <= asm_d;
            idx_q       <= idx_d;
            dump_word_q <= dump_word_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        pipe_en_d   = 1'b0;
        flush_d     = 1'b0;
        reg_addr_d  = reg_addr_q;
        halted_d    = halted_q;
        byte_cnt_d  = byte_cnt_q;
        word_addr_d = word_addr_q;
        asm_d       = asm_q;
        idx_d       = idx_q;
        dump_word_d = dump_word_q;

        asm_next = {asm_q[NB_DATA-9:0], i_rx_data};
        dump_sel = (idx_q == '0) ? i_pc : i_reg_data;

        unique case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD) begin
                        state_d     = ST_LOAD;
                        word_addr_d = '0;
                        byte_cnt_d  = '0;
                        halted_d    = 1'b0;
                    end else if (i_rx_data == CMD_CONT && !halted_q) begin
                        state_d = ST_RUN;
                    end else if (i_rx_data == CMD_STEP && !halted_q) begin
                        // Enable is registered, so raising it here makes it
                        // high for exactly the one cycle spent in STEP.
                        state_d   = ST_STEP;
                        pipe_en_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (i_rx_valid) begin
                    asm_d = asm_next;
                    if (byte_cnt_q == 2'd3) begin
                        state_d     = ST_LOAD_WR;
                        byte_cnt_d  = '0;
                        imem_we_d   = 1'b1;
                        imem_addr_d = word_addr_q;
                        imem_data_d = asm_next;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end

            ST_LOAD_WR: begin
                // The write is on the bus this cycle; decide whether the
                // program is complete (HALT word or memory full).
                if (imem_data_q == '1 || word_addr_q == '1) begin
                    state_d = ST_IDLE;
                    flush_d = 1'b1;
                end else begin
                    state_d     = ST_LOAD;
                    word_addr_d = word_addr_q + 1'b1;
                end
            end

            ST_RUN: begin
                if (i_halt) begin
                    state_d    = ST_DUMP_LD;
                    halted_d   = 1'b1;
                    idx_d      = '0;
                    reg_addr_d = '0;
                    byte_cnt_d = '0;
                end else begin
                    pipe_en_d = 1'b1;
                end
            end

            ST_STEP: begin
                state_d    = ST_DUMP_LD;
                halted_d   = halted_q | i_halt;
                idx_d      = '0;
                reg_addr_d = '0;
                byte_cnt_d = '0;
            end

            ST_DUMP_LD: begin
                // o_reg_addr was registered on the way in, so i_reg_data has
                // settled by now. Byte 0 goes out immediately; the remaining
                // three are shifted up for later.
                state_d     = ST_DUMP_TX;
                tx_data_d   = dump_sel[NB_DATA-1 -: 8];
                tx_start_d  = 1'b1;
                dump_word_d = {dump_sel[NB_DATA-9:0], 8'h00};
                byte_cnt_d  = '0;
            end

            ST_DUMP_TX: begin
                state_d = ST_DUMP_WAIT;
            end

            ST_DUMP_WAIT: begin
                if (i_tx_done) begin
                    if (byte_cnt_q == 2'd3) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d    = ST_DUMP_LD;
                            idx_d      = idx_q + 1'b1;
                            // Register k-1 backs dump index k.
                            reg_addr_d = idx_q[NB_REG_ADDR-1:0];
                        end
                    end else begin
                        state_d     = ST_DUMP_TX;
                        byte_cnt_d  = byte_cnt_q + 1'b1;
                        tx_data_d   = dump_word_q[NB_DATA-1 -: 8];
                        tx_start_d  = 1'b1;
                        dump_word_d = {dump_word_q[NB_DATA-9:0], 8'h00};
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_tx_data         = tx_data_q;
    assign o_tx_start        = tx_start_q;
    assign o_imem_we         = imem_we_q;
    assign o_imem_addr       = imem_addr_q;
    assign o_imem_data       = imem_data_q;
    assign o_pipeline_enable = pipe_en_q;
    assign o_pipeline_flush  = flush_q;
    assign o_reg_addr        = reg_addr_q;
    assign o_halted          = halted_q;
    assign o_state           = state_q;

endmodule

// File: tb/tb_debug_unit_controller.sv
// -----------------------------------------------------------------------------
// tb_debug_unit_controller
//
// Directed bench for debug_unit_controller. A table of per-cycle vectors covers
// the load protocol; hand-written sequences cover step, run-to-halt, ignored
// commands, and reset in the middle of a dump. A small transmitter model
// answers every o_tx_start with i_tx_done a few cycles later and records the
// transmitted bytes; the register file is modelled as Rk = k and PC = 4.
// -----------------------------------------------------------------------------
module tb_debug_unit_controller;

    localparam int NB_DATA     = 32;
    localparam int IMEM_ADDR_W = 10;
    localparam int NB_REG_ADDR = 5;
    localparam int DUMP_BYTES  = 132;

    logic                   clk;
    logic                   i_reset;
    logic [7:0]             i_rx_data;
    logic                   i_rx_valid;
    logic [7:0]             o_tx_data;
    logic                   o_tx_start;
    logic                   i_tx_done;
    logic                   o_imem_we;
    logic [IMEM_ADDR_W-1:0] o_imem_addr;
    logic [NB_DATA-1:0]     o_imem_data;
    logic                   o_pipeline_enable;
    logic                   o_pipeline_flush;
    logic                   i_halt;
    logic [NB_DATA-1:0]     i_pc;
    logic [NB_REG_ADDR-1:0] o_reg_addr;
    logic [NB_DATA-1:0]     i_reg_data;
    logic                   o_halted;
    logic [2:0]             o_state;

    debug_unit_controller #(
        .NB_DATA     (NB_DATA),
        .IMEM_ADDR_W (IMEM_ADDR_W),
        .NB_REG_ADDR (NB_REG_ADDR)
    ) dut (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .i_rx_data         (i_rx_data),
        .i_rx_valid        (i_rx_valid),
        .o_tx_data         (o_tx_data),
        .o_tx_start        (o_tx_start),
        .i_tx_done         (i_tx_done),
        .o_imem_we         (o_imem_we),
        .o_imem_addr       (o_imem_addr),
        .o_imem_data       (o_imem_data),
        .o_pipeline_enable (o_pipeline_enable),
        .o_pipeline_flush  (o_pipeline_flush),
        .i_halt            (i_halt),
        .i_pc              (i_pc),
        .o_reg_addr        (o_reg_addr),
        .i_reg_data        (i_reg_data),
        .o_halted          (o_halted),
        .o_state           (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: Rk holds k.
    assign i_reg_data = {{(NB_DATA-NB_REG_ADDR){1'b0}}, o_reg_addr};
    assign i_pc       = 32'd4;

    // ---------------------------------------------------------------------
    // Transmitter model and event log (sampled on the falling edge).
    // ---------------------------------------------------------------------
    logic [7:0]             cap [0:1023];
    int                     ncap = 0;
    int                     nviol = 0;
    int                     nunstable = 0;
    int                     nen = 0;
    int                     nfl = 0;
    int                     nwe = 0;
    logic [IMEM_ADDR_W-1:0] we_addr [0:15];
    logic [NB_DATA-1:0]     we_data [0:15];
    logic                   busy = 1'b0;
    int                     dly = 0;
    logic [7:0]             last_byte = 8'h00;

    initial i_tx_done = 1'b0;

    always @(negedge clk) begin
        i_tx_done = 1'b0;
        if (!i_reset) begin
            busy = 1'b0;
        end else if (o_tx_start) begin
            if (busy) nviol++;
            busy      = 1'b1;
            dly       = 2;
            last_byte = o_tx_data;
            cap[ncap % 1024] = o_tx_data;
            ncap++;
        end else if (busy) begin
            if (o_tx_data !== last_byte) nunstable++;
            if (dly == 0) begin
                i_tx_done = 1'b1;
                busy      = 1'b0;
            end else begin
                dly--;
            end
        end
        if (o_imem_we) begin
            we_addr[nwe % 16] = o_imem_addr;
            we_data[nwe % 16] = o_imem_data;
            nwe++;
        end
        if (o_pipeline_flush)  nfl++;
        if (o_pipeline_enable) nen++;
    end

    // ---------------------------------------------------------------------
    // Checking helpers
    // ---------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (o_state == 3'd0) break;
            @(negedge clk);
        end
        chk(name, {61'd0, o_state}, 64'd0);
    endtask

    // Compares a full dump starting at capture index base against PC=4, Rk=k.
    task automatic check_dump(input string name, input int base);
        int         errs;
        int         first;
        logic [31:0] w;
        logic [7:0]  exp_b;
        errs  = 0;
        first = -1;
        for (int k = 0; k <= 32; k++) begin
            w = (k == 0) ? 32'd4 : 32'(k - 1);
            for (int j = 0; j < 4; j++) begin
                exp_b = w[31 - 8*j -: 8];
                if (cap[(base + 4*k + j) % 1024] !== exp_b) begin
                    errs++;
                    if (first < 0) first = 4*k + j;
                end
            end
        end
        chk({name, "_count"}, 64'(ncap - base), 64'(DUMP_BYTES));
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s_bytes actual=%0d wrong bytes (first at %0d) required=0", name, errs, first);
        end
        chk({name, "_handshake"}, 64'(nviol), 64'd0);
        chk({name, "_stable"}, 64'(nunstable), 64'd0);
    endtask

    // ---------------------------------------------------------------------
    // Load-protocol vector table
    // ---------------------------------------------------------------------
    typedef struct {
        logic                   v;
        logic [7:0]             d;
        logic [2:0]             st;
        logic                   we;
        logic [IMEM_ADDR_W-1:0] addr;
        logic [NB_DATA-1:0]     data;
        logic                   fl;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [2:0] st,
                                input logic we, input logic [IMEM_ADDR_W-1:0] addr,
                                input logic [NB_DATA-1:0] data, input logic fl);
        vec_t r;
        r.v = v; r.d = d; r.st = st; r.we = we; r.addr = addr; r.data = data; r.fl = fl;
        return r;
    endfunction

    vec_t vt [0:18];

    initial begin
        int base;
        int cnt;
        int en0;
        int k;

        vt[0]  = mk(1'b1, 8'h58, 3'd0, 1'b0, 10'd0, 32'h0,        1'b0); // 'X' ignored
        vt[1]  = mk(1'b1, 8'h4C, 3'd1, 1'b0, 10'd0, 32'h0,        1'b0); // 'L'
        vt[2]  = mk(1'b1, 8'h20, 3'd1, 1'b0, 10'd0, 32'h0,        1'b0);
        vt[3]  = mk(1'b1, 8'hA5, 3'd1, 1'b0, 10'd0, 32'h0,        1'b0);
        vt[4]  = mk(1'b0, 8'h00, 3'd1, 1'b0, 10'd0, 32'h0,        1'b0); // gap
        vt[5]  = mk(1'b1, 8'h00, 3'd1, 1'b0, 10'd0, 32'h0,        1'b0);
        vt[6]  = mk(1'b1, 8'h04, 3'd2, 1'b1, 10'd0, 32'h20A50004, 1'b0);
        vt[7]  = mk(1'b1, 8'h77, 3'd1, 1'b0, 10'd0, 32'h0,        1'b0); // ignored in LOAD_WR
        vt[8]  = mk(1'b1, 8'h00, 3'd1, 1'b0, 10'd0, 32'h0,        1'b0);
        vt[9]  = mk(1'b1, 8'h00, 3'd1, 1'b0, 10'd0, 32'h0,        1'b0);
        vt[10] = mk(1'b1, 8'h00, 3'd1, 1'b0, 10'd0, 32'h0,        1'b0);
        vt[11] = mk(1'b1, 8'h00, 3'd2, 1'b1, 10'd1, 32'h00000000, 1'b0);
        vt[12] = mk(1'b0, 8'h00, 3'd1, 1'b0, 10'd0, 32'h0,        1'b0);
        vt[13] = mk(1'b1, 8'hFF, 3'd1, 1'b0, 10'd0, 32'h0,        1'b0);
        vt[14] = mk(1'b1, 8'hFF, 3'd1, 1'b0, 10'd0, 32'h0,        1'b0);
        vt[15] = mk(1'b1, 8'hFF, 3'd1, 1'b0, 10'd0, 32'h0,        1'b0);
        vt[16] = mk(1'b1, 8'hFF, 3'd2, 1'b1, 10'd2, 32'hFFFFFFFF, 1'b0);
        vt[17] = mk(1'b0, 8'h00, 3'd0, 1'b0, 10'd0, 32'h0,        1'b1); // flush pulse
        vt[18] = mk(1'b0, 8'h00, 3'd0, 1'b0, 10'd0, 32'h0,        1'b0);

        i_reset    = 1'b0;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h4C;
        i_halt     = 1'b0;

        // Reset held with an 'L' strobe present: everything stays at zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs",
                {1'b0, o_tx_data, o_tx_start, o_imem_we, o_imem_addr, o_imem_data,
                 o_pipeline_enable, o_pipeline_flush, o_reg_addr, o_halted, o_state},
                64'd0);
        end
        i_rx_valid = 1'b0;
        i_reset    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_idle", {61'd0, o_state}, 64'd0);
        end

        // Load program through the vector table.
        for (int i = 0; i < 19; i++) begin
            i_rx_valid = vt[i].v;
            i_rx_data  = vt[i].d;
            @(negedge clk);
            chk($sformatf("load%0d_state", i), {61'd0, o_state}, {61'd0, vt[i].st});
            chk($sformatf("load%0d_we", i), {63'd0, o_imem_we}, {63'd0, vt[i].we});
            chk($sformatf("load%0d_flush", i), {63'd0, o_pipeline_flush}, {63'd0, vt[i].fl});
            if (vt[i].we) begin
                chk($sformatf("load%0d_addr", i), {54'd0, o_imem_addr}, {54'd0, vt[i].addr});
                chk($sformatf("load%0d_data", i), {32'd0, o_imem_data}, {32'd0, vt[i].data});
            end
        end
        i_rx_valid = 1'b0;
        chk("load_we_pulses", 64'(nwe), 64'd3);
        chk("load_flush_pulses", 64'(nfl), 64'd1);
        chk("load_log_addr2", {54'd0, we_addr[2]}, 64'd2);

        // Single step followed by a full dump.
        en0  = nen;
        base = ncap;
        send_byte(8'h53);
        chk("step_state", {61'd0, o_state}, 64'd4);
        chk("step_enable", {63'd0, o_pipeline_enable}, 64'd1);
        wait_idle("step_dump_done");
        chk("step_enable_cycles", 64'(nen - en0), 64'd1);
        chk("step_pc_b3", {56'd0, cap[(base + 3) % 1024]}, 64'h04);
        chk("step_r1_b3", {56'd0, cap[(base + 11) % 1024]}, 64'h01);
        chk("step_r31_b3", {56'd0, cap[(base + 131) % 1024]}, 64'h1F);
        chk("step_halted", {63'd0, o_halted}, 64'd0);
        check_dump("step_dump", base);

        // Continuous run, HALT after 10 enabled cycles; an 'L' mid-run is ignored.
        en0  = nen;
        base = ncap;
        send_byte(8'h43);
        chk("run_state", {61'd0, o_state}, 64'd3);
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 10; i++) begin
            @(negedge clk);
            if (o_pipeline_enable) cnt++;
            i_rx_data  = 8'h4C;
            i_rx_valid = (cnt == 5);
        end
        i_rx_valid = 1'b0;
        chk("run_enable_cycles_seen", 64'(cnt), 64'd10);
        chk("run_state_held", {61'd0, o_state}, 64'd3);
        i_halt = 1'b1;
        @(negedge clk);
        i_halt = 1'b0;
        chk("run_halt_enable", {63'd0, o_pipeline_enable}, 64'd0);
        chk("run_halted", {63'd0, o_halted}, 64'd1);
        chk("run_halt_state", {61'd0, o_state}, 64'd5);
        wait_idle("run_dump_done");
        chk("run_enable_total", 64'(nen - en0), 64'd10);
        check_dump("run_dump", base);

        // While halted, 'C' and 'S' are ignored; 'X' is ignored always.
        en0 = nen;
        send_byte(8'h43);
        chk("halted_c_state", {61'd0, o_state}, 64'd0);
        send_byte(8'h53);
        chk("halted_s_state", {61'd0, o_state}, 64'd0);
        send_byte(8'h58);
        chk("x_state", {61'd0, o_state}, 64'd0);
        @(negedge clk);
        chk("halted_no_enable", 64'(nen - en0), 64'd0);
        chk("halted_kept", {63'd0, o_halted}, 64'd1);

        // A reset pulse clears the halted flag.
        i_reset = 1'b0;
        @(negedge clk);
        chk("reset_clears_halted", {63'd0, o_halted}, 64'd0);
        i_reset = 1'b1;
        @(negedge clk);

        // 'S' arriving during DUMP_WAIT must not disturb the dump.
        base = ncap;
        send_byte(8'h53);
        for (int i = 0; i < 200; i++) begin
            if (o_state == 3'd7) break;
            @(negedge clk);
        end
        chk("reach_dump_wait", {61'd0, o_state}, 64'd7);
        send_byte(8'h53);
        wait_idle("s_in_wait_done");
        check_dump("s_in_wait_dump", base);

        // Reset during the 51st byte, then a fresh dump.
        send_byte(8'h53);
        k = 0;
        for (int i = 0; i < 2000 && k < 51; i++) begin
            @(negedge clk);
            if (o_tx_start) k++;
        end
        chk("mid_dump_reached", 64'(k), 64'd51);
        #2 i_reset = 1'b0;
        #1;
        chk("mid_reset_tx_start", {63'd0, o_tx_start}, 64'd0);
        chk("mid_reset_state", {61'd0, o_state}, 64'd0);
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        chk("post_mid_reset_idle", {61'd0, o_state}, 64'd0);
        base = ncap;
        send_byte(8'h53);
        wait_idle("fresh_dump_done");
        chk("fresh_pc_b3", {56'd0, cap[(base + 3) % 1024]}, 64'h04);
        check_dump("fresh_dump", base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
